// File: rtl/bm_pkg.sv
// Shared block-matching types used by the disparity selection stage and by
// the left-right consistency checker.
//   cost_t       : 8-bit Hamming cost
//   coords_t     : {row, col} pixel coordinate, row in [1], col in [0]
//   COST_MAX     : saturated cost; the second-best cost starts here
//   disp_state_e : winner-take-all FSM states
package bm_pkg;
    typedef logic [7:0]      cost_t;
    typedef logic [1:0][7:0] coords_t;

    localparam cost_t COST_MAX = 8'hFF;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } disp_state_e;
endpackage

// File: rtl/hamming_disp_select_if.sv
// Bus between the Hamming cost stage, the disparity selector and the
// disparity map writer.
//   Cost record : sum, in_coords, blk_index_i, sum_valid, uniq_thresh
//   Result      : disp_o, min_cost, second_cost, unique_o, out_coords,
//                 disp_valid, seq_err
// master drives cost records and observes results; slave is the selector.
interface hamming_disp_select_if #(
    parameter int COST_W = 8
);
    import bm_pkg::*;

    logic [COST_W-1:0] sum;
    coords_t           in_coords;
    logic [15:0]       blk_index_i;
    logic              sum_valid;
    logic [COST_W-1:0] uniq_thresh;

    logic [15:0]       disp_o;
    logic [COST_W-1:0] min_cost;
    logic [COST_W-1:0] second_cost;
    logic              unique_o;
    coords_t           out_coords;
    logic              disp_valid;
    logic              seq_err;

    modport master (
        output sum, in_coords, blk_index_i, sum_valid, uniq_thresh,
        input  disp_o, min_cost, second_cost, unique_o, out_coords,
               disp_valid, seq_err
    );

    modport slave (
        input  sum, in_coords, blk_index_i, sum_valid, uniq_thresh,
        output disp_o, min_cost, second_cost, unique_o, out_coords,
               disp_valid, seq_err
    );
endinterface

// File: rtl/hamming_disp_select_min2_update.sv
// Combinational best/second-best update for one candidate.
//   best_i/second_i/best_idx_i : running triple
//   sum_i/idx_i                : new candidate cost and index
//   best_o/second_o/best_idx_o : updated triple
// Strict less-than: on ties the earlier (lower) index keeps the win.
module min2_update #(
    parameter int COST_W = 8,
    parameter int IDX_W  = 6
) (
    input  logic [COST_W-1:0] best_i,
    input  logic [COST_W-1:0] second_i,
    input  logic [IDX_W-1:0]  best_idx_i,
    input  logic [COST_W-1:0] sum_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [COST_W-1:0] best_o,
    output logic [COST_W-1:0] second_o,
    output logic [IDX_W-1:0]  best_idx_o
);
    always_comb begin
        best_o     = best_i;
        second_o   = second_i;
        best_idx_o = best_idx_i;
        if (sum_i < best_i) begin
            second_o   = best_i;
            best_o     = sum_i;
            best_idx_o = idx_i;
        end else if (sum_i < second_i) begin
            second_o = sum_i;
        end
    end
endmodule

// File: rtl/hamming_disp_select.sv
// Winner-take-all disparity selection over NUM_DISP consecutive Hamming cost
// records per pixel coordinate.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : slave side of hamming_disp_select_if (cost records in,
//                disparity results and protocol-error strobe out)
// The final candidate is folded in combinationally and registered straight
// into the result registers, so a result appears one cycle after its last
// record and back-to-back coordinates need no dead cycle.
module hamming_disp_select
    import bm_pkg::*;
#(
    parameter int NUM_DISP = 64,
    parameter int COST_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    hamming_disp_select_if.slave  bus
);
    localparam int          DISP_W   = (NUM_DISP > 1) ? $clog2(NUM_DISP) : 1;
    localparam logic [15:0] LAST_IDX = 16'(NUM_DISP - 1);

    // Margin is taken one bit wider so the subtraction cannot wrap.
    function automatic logic uniq_check(input logic [COST_W-1:0] best,
                                        input logic [COST_W-1:0] second,
                                        input logic [COST_W-1:0] thr);
        logic [COST_W:0] margin;
        margin = {1'b0, second} - {1'b0, best};
        return margin >= {1'b0, thr};
    endfunction

    disp_state_e       state_q,  state_d;
    logic [COST_W-1:0] best_q,   best_d;
    logic [COST_W-1:0] second_q, second_d;
    logic [DISP_W-1:0] idx_q,    idx_d;
    logic [15:0]       exp_q,    exp_d;
    coords_t           coords_q, coords_d;

    logic [DISP_W-1:0] disp_q,    disp_d;
    logic [COST_W-1:0] min_q,     min_d;
    logic [COST_W-1:0] sec_out_q, sec_out_d;
    logic              uniq_q,    uniq_d;
    coords_t           oc_q,      oc_d;
    logic              dv_q,      dv_d;
    logic              se_q,      se_d;

    logic [COST_W-1:0] upd_best;
    logic [COST_W-1:0] upd_second;
    logic [DISP_W-1:0] upd_idx;

    min2_update #(
        .COST_W (COST_W),
        .IDX_W  (DISP_W)
    ) u_min2 (
        .best_i     (best_q),
        .second_i   (second_q),
        .best_idx_i (idx_q),
        .sum_i      (bus.sum),
        .idx_i      (bus.blk_index_i[DISP_W-1:0]),
        .best_o     (upd_best),
        .second_o   (upd_second),
        .best_idx_o (upd_idx)
    );

    always_comb begin
        state_d   = state_q;
        best_d    = best_q;
        second_d  = second_q;
        idx_d     = idx_q;
        exp_d     = exp_q;
        coords_d  = coords_q;
        disp_d    = disp_q;
        min_d     = min_q;
        sec_out_d = sec_out_q;
        uniq_d    = uniq_q;
        oc_d      = oc_q;
        dv_d      = 1'b0;
        se_d      = 1'b0;

        if (bus.sum_valid) begin
            if (bus.blk_index_i == 16'd0) begin
                // Index 0 always opens a new coordinate; mid-sequence it
                // also flags the abandoned one.
                se_d     = (state_q == ACCUM);
                best_d   = bus.sum;
                second_d = '1;
                idx_d    = '0;
                coords_d = bus.in_coords;
                exp_d    = 16'd1;
                if (NUM_DISP == 1) begin
                    dv_d      = 1'b1;
                    disp_d    = '0;
                    min_d     = bus.sum;
                    sec_out_d = '1;
                    uniq_d    = uniq_check(bus.sum, '1, bus.uniq_thresh);
                    oc_d      = bus.in_coords;
                    state_d   = IDLE;
                end else begin
                    state_d = ACCUM;
                end
            end else if (state_q == IDLE) begin
                se_d = 1'b1;
            end else if (bus.blk_index_i == exp_q && bus.in_coords == coords_q) begin
                best_d   = upd_best;
                second_d = upd_second;
                idx_d    = upd_idx;
                exp_d    = exp_q + 16'd1;
                if (bus.blk_index_i == LAST_IDX) begin
                    dv_d      = 1'b1;
                    disp_d    = upd_idx;
                    min_d     = upd_best;
                    sec_out_d = upd_second;
                    uniq_d    = uniq_check(upd_best, upd_second, bus.uniq_thresh);
                    oc_d      = coords_q;
                    state_d   = IDLE;
                end
            end else begin
                // Gap, out-of-range index or coordinate change: drop it.
                se_d    = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            best_q    <= '0;
            second_q  <= '0;
            idx_q     <= '0;
            exp_q     <= '0;
            coords_q  <= '0;
            disp_q    <= '0;
            min_q     <= '0;
            sec_out_q <= '0;
            uniq_q    <= 1'b0;
            oc_q      <= '0;
            dv_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            best_q    <= best_d;
            second_q  <= second_d;
            idx_q     <= idx_d;
            exp_q     <= exp_d;
            coords_q  <= coords_d;
            disp_q    <= disp_d;
            min_q     <= min_d;
            sec_out_q <= sec_out_d;
            uniq_q    <= uniq_d;
            oc_q      <= oc_d;
            dv_q      <= dv_d;
            se_q      <= se_d;
        end
    end

    assign bus.disp_o      = 16'(disp_q);
    assign bus.min_cost    = min_q;
    assign bus.second_cost = sec_out_q;
    assign bus.unique_o    = uniq_q;
    assign bus.out_coords  = oc_q;
    assign bus.disp_valid  = dv_q;
    assign bus.seq_err     = se_q;
endmodule

// File: tb/tb_hamming_disp_select.sv
// Bench for hamming_disp_select with NUM_DISP=4: directed record sequences,
// a queue-and-sort reference model, a per-cycle compare process and a few
// hand-computed literal expectations.
module tb_hamming_disp_select;
    localparam int ND = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hamming_disp_select_if #(.COST_W(CW)) bus();

    hamming_disp_select #(.NUM_DISP(ND), .COST_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference state: costs collected so far for the open coordinate.
    int          mcost[$];
    logic [15:0] mcoords;
    bit          mact = 1'b0;

    logic [15:0] exp_disp = '0;
    logic [7:0]  exp_min  = '0;
    logic [7:0]  exp_sec  = '0;
    logic        exp_uq   = 1'b0;
    logic [15:0] exp_oc   = '0;
    logic        exp_dv   = 1'b0;
    logic        exp_se   = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("disp_valid",  32'(bus.disp_valid),  32'(exp_dv));
            chk("seq_err",     32'(bus.seq_err),     32'(exp_se));
            chk("disp_o",      32'(bus.disp_o),      32'(exp_disp));
            chk("min_cost",    32'(bus.min_cost),    32'(exp_min));
            chk("second_cost", 32'(bus.second_cost), 32'(exp_sec));
            chk("unique",      32'(bus.unique_o),    32'(exp_uq));
            chk("out_coords",  32'(bus.out_coords),  32'(exp_oc));
        end
    end

    // Drive one cycle of inputs, predict the outputs after the next edge.
    task automatic step(input bit r, input bit v, input int idx,
                        input logic [15:0] c, input int cost, input int thr);
        logic [15:0] p_disp = exp_disp;
        logic [7:0]  p_min  = exp_min;
        logic [7:0]  p_sec  = exp_sec;
        logic        p_uq   = exp_uq;
        logic [15:0] p_oc   = exp_oc;
        bit          dv     = 1'b0;
        bit          se     = 1'b0;
        bit          emit   = 1'b0;

        reset           = r;
        bus.sum_valid   = v;
        bus.blk_index_i = idx[15:0];
        bus.in_coords   = c;
        bus.sum         = cost[7:0];
        bus.uniq_thresh = thr[7:0];

        if (r) begin
            mact = 1'b0;
            mcost.delete();
            p_disp = '0; p_min = '0; p_sec = '0; p_uq = 1'b0; p_oc = '0;
        end else if (v) begin
            if (idx == 0) begin
                se = mact;
                mact = 1'b1;
                mcost.delete();
                mcost.push_back(cost);
                mcoords = c;
                emit = (mcost.size() == ND);
            end else if (!mact) begin
                se = 1'b1;
            end else if (idx == mcost.size() && c == mcoords) begin
                mcost.push_back(cost);
                emit = (mcost.size() == ND);
            end else begin
                se = 1'b1;
                mact = 1'b0;
            end
        end

        if (emit) begin
            int s[$];
            int best, sec, arg;
            s = mcost;
            s.sort();
            best = s[0];
            sec  = (s.size() > 1) ? s[1] : 255;
            arg  = -1;
            for (int i = 0; i < mcost.size(); i++)
                if (arg < 0 && mcost[i] == best) arg = i;
            dv     = 1'b1;
            mact   = 1'b0;
            p_disp = 16'(arg);
            p_min  = best[7:0];
            p_sec  = sec[7:0];
            p_uq   = ((sec - best) >= thr);
            p_oc   = mcoords;
        end

        @(posedge clk);
        #1;
        exp_disp = p_disp; exp_min = p_min; exp_sec = p_sec; exp_uq = p_uq;
        exp_oc = p_oc; exp_dv = dv; exp_se = se;
        chk_en = 1'b1;
    endtask

    task automatic rec(input int idx, input logic [15:0] c, input int cost,
                       input int thr);
        step(1'b0, 1'b1, idx, c, cost, thr);
    endtask

    task automatic bubble(input int thr);
        step(1'b0, 1'b0, 0, 16'h0000, 0, thr);
    endtask

    int costs_a[4] = '{20, 7, 7, 30};
    int costs_b[4] = '{50, 10, 40, 45};
    int costs_c[4] = '{5, 4, 3, 2};

    initial begin
        step(1'b1, 1'b0, 0, 16'h0000, 0, 0);
        step(1'b1, 1'b0, 0, 16'h0000, 0, 0);
        chk("reset_dv",   32'(bus.disp_valid), 32'd0);
        chk("reset_disp", 32'(bus.disp_o),     32'd0);

        // Ties: the lower index wins and second equals best.
        for (int i = 0; i < 4; i++) rec(i, 16'h0305, costs_a[i], 0);
        chk("t1_dv",   32'(bus.disp_valid),  32'd1);
        chk("t1_disp", 32'(bus.disp_o),      32'd1);
        chk("t1_min",  32'(bus.min_cost),    32'd7);
        chk("t1_sec",  32'(bus.second_cost), 32'd7);
        chk("t1_uq",   32'(bus.unique_o),    32'd1);
        bubble(0);

        // Threshold is only looked at on the last record.
        for (int i = 0; i < 4; i++) rec(i, 16'h0305, costs_a[i], (i == 3) ? 1 : 0);
        chk("t2_uq", 32'(bus.unique_o), 32'd0);
        bubble(0);

        for (int i = 0; i < 4; i++) rec(i, 16'h0305, costs_b[i], 30);
        chk("t3_disp", 32'(bus.disp_o),      32'd1);
        chk("t3_sec",  32'(bus.second_cost), 32'd40);
        chk("t3_uq",   32'(bus.unique_o),    32'd1);

        // Back-to-back coordinates, no bubbles.
        for (int i = 0; i < 4; i++) rec(i, 16'h0102, costs_c[i], 0);
        chk("t4a_oc",   32'(bus.out_coords), 32'h0102);
        chk("t4a_disp", 32'(bus.disp_o),     32'd3);
        for (int i = 0; i < 4; i++) rec(i, 16'h0A0B, 9, 0);
        chk("t4b_oc",   32'(bus.out_coords), 32'h0A0B);
        chk("t4b_disp", 32'(bus.disp_o),     32'd0);
        chk("t4b_min",  32'(bus.min_cost),   32'd9);
        bubble(0);

        // Index gap 0,1,3 then a stray index while idle, then a full run.
        rec(0, 16'h0203, 11, 0);
        rec(1, 16'h0203, 12, 0);
        rec(3, 16'h0203, 13, 0);
        chk("t5_se", 32'(bus.seq_err),    32'd1);
        chk("t5_dv", 32'(bus.disp_valid), 32'd0);
        rec(2, 16'h0203, 13, 0);
        for (int i = 0; i < 4; i++) rec(i, 16'h0203, 40 - i * 3, 5);

        // Restart mid-sequence.
        rec(0, 16'h0404, 1, 0);
        rec(1, 16'h0404, 2, 0);
        for (int i = 0; i < 4; i++) rec(i, 16'h0505, 60 + i, 1);
        bubble(0);

        // Coordinate change at idx2, and an out-of-range index.
        rec(0, 16'h0606, 3, 0);
        rec(1, 16'h0606, 4, 0);
        rec(2, 16'h0607, 5, 0);
        rec(3, 16'h0606, 6, 0);
        rec(0, 16'h0707, 3, 0);
        rec(1, 16'h0707, 4, 0);
        rec(2, 16'h0707, 5, 0);
        rec(5, 16'h0707, 6, 0);
        bubble(0);

        // Reset mid-accumulation with a record arriving during reset.
        rec(0, 16'h0808, 30, 0);
        rec(1, 16'h0808, 20, 0);
        rec(2, 16'h0808, 10, 0);
        step(1'b1, 1'b1, 3, 16'h0808, 1, 0);
        chk("t8_rst_dv",   32'(bus.disp_valid), 32'd0);
        chk("t8_rst_disp", 32'(bus.disp_o),     32'd0);
        for (int i = 0; i < 4; i++) rec(i, 16'h0909, 100 - i * 10, 20);
        chk("t8_disp", 32'(bus.disp_o), 32'd3);
        bubble(0);

        // Bubbles between every record.
        for (int i = 0; i < 4; i++) begin
            rec(i, 16'h0305, costs_b[i], 30);
            if (i < 3) bubble(0);
        end
        chk("t9_dv",   32'(bus.disp_valid), 32'd1);
        chk("t9_disp", 32'(bus.disp_o),     32'd1);
        bubble(0);
        bubble(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
